// File: rtl/dso_pkg.sv
// Shared definitions for the capture front end: FSM state codes, the default
// sample-memory address width, and a small state-decoding helper.
package dso_pkg;

  // Default sample-memory address width (depth 2^AW words).
  localparam int DSO_AW_DEFAULT = 12;

  // Capture FSM state codes, kept as plain constants so the state output
  // stays a simple 3-bit code for legacy consumers.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_POST = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // True while a capture is actively writing (PRE, WAIT or POST).
  function automatic logic state_is_busy(input logic [2:0] st);
    return (st == ST_PRE) || (st == ST_WAIT) || (st == ST_POST);
  endfunction

endpackage

// File: rtl/capture_mem_ctrl_if.sv
// Bundle of the capture controller's control, sample and memory-side signals.
// The master side (sequencer / host model) drives requests and samples; the
// slave side is the capture controller itself.
interface capture_mem_ctrl_if #(
  parameter int AW = dso_pkg::DSO_AW_DEFAULT
);
  logic          arm;
  logic          abort;
  logic [AW-1:0] pre_count;
  logic          sample_valid;
  logic          trig;
  logic [AW-1:0] rd_addr_in;
  logic          rd_release;
  logic [AW-1:0] mem_addr;
  logic          wr_en;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] trig_addr;
  logic          rd_grant;
  logic          busy;
  logic [2:0]    state;

  modport master (
    output arm, abort, pre_count, sample_valid, trig, rd_addr_in, rd_release,
    input  mem_addr, wr_en, start_addr, trig_addr, rd_grant, busy, state
  );

  modport slave (
    input  arm, abort, pre_count, sample_valid, trig, rd_addr_in, rd_release,
    output mem_addr, wr_en, start_addr, trig_addr, rd_grant, busy, state
  );
endinterface

// File: rtl/capture_addr_gen.sv
// Circular write pointer for the sample memory: synchronous clear, advance on
// enable, wraps naturally modulo 2^AW.
module capture_addr_gen #(
  parameter int AW = dso_pkg::DSO_AW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [AW-1:0] ptr_o
);

  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  // Next pointer: clear wins, otherwise step by one on each write.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)     ptr_d = '0;
    else if (en_i) ptr_d = ptr_q + 1'b1;
  end

  // Pointer register.
  // NOTE: sequential state is only ever assigned with <= so every flop samples
  // the pre-edge values of its neighbours; blocking here would create races.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/capture_mem_ctrl.sv
// Pre/post-trigger capture controller for a circular sample memory. Arms on
// request, fills the pre-trigger window, writes circularly until a qualified
// trigger, fills the post-trigger window so that exactly 2^AW samples are
// held, then hands the memory to the SPI reader with addresses rebased to the
// oldest sample.
module capture_mem_ctrl
  import dso_pkg::*;
#(
  parameter int AW = DSO_AW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          arm,
  input  logic          abort,
  input  logic [AW-1:0] pre_count,
  input  logic          sample_valid,
  input  logic          trig,
  input  logic [AW-1:0] rd_addr_in,
  input  logic          rd_release,
  output logic [AW-1:0] mem_addr,
  output logic          wr_en,
  output logic [AW-1:0] start_addr,
  output logic [AW-1:0] trig_addr,
  output logic          rd_grant,
  output logic          busy,
  output logic [2:0]    state
);

  logic [2:0]    state_q,      state_d;
  logic [AW-1:0] pre_len_q,    pre_len_d;     // pre_count latched at arm
  logic [AW-1:0] pre_cnt_q,    pre_cnt_d;     // pre-trigger writes so far
  logic [AW-1:0] post_cnt_q,   post_cnt_d;    // post-trigger writes remaining
  logic [AW-1:0] trig_addr_q,  trig_addr_d;
  logic [AW-1:0] start_addr_q, start_addr_d;

  logic [AW-1:0] wr_ptr;
  logic          ptr_clr;
  logic [AW-1:0] pre_cnt_inc;

  assign pre_cnt_inc = pre_cnt_q + 1'b1;

  // Write enable is combinational so a sample is stored in the cycle it is
  // presented. An empty pre window (length 0) and an already-full post window
  // (counter 0) must not write, so both are masked here.
  always_comb begin
    wr_en = 1'b0;
    if (sample_valid && !abort) begin
      unique case (state_q)
        ST_PRE:  wr_en = (pre_len_q != '0);
        ST_WAIT: wr_en = 1'b1;
        ST_POST: wr_en = (post_cnt_q != '0);
        default: wr_en = 1'b0;
      endcase
    end
  end

  capture_addr_gen #(.AW(AW)) u_addr_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (ptr_clr),
    .en_i    (wr_en),
    .ptr_o   (wr_ptr)
  );

  // Capture sequencing: abort overrides everything, otherwise step the FSM.
  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    pre_len_d    = pre_len_q;
    pre_cnt_d    = pre_cnt_q;
    post_cnt_d   = post_cnt_q;
    trig_addr_d  = trig_addr_q;
    start_addr_d = start_addr_q;
    ptr_clr      = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_d   = ST_PRE;
            ptr_clr   = 1'b1;
            pre_cnt_d = '0;
            pre_len_d = pre_count;
          end
        end
        ST_PRE: begin
          if (pre_len_q == '0) begin
            state_d = ST_WAIT;
          end else if (sample_valid) begin
            pre_cnt_d = pre_cnt_inc;
            if (pre_cnt_inc == pre_len_q) state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (sample_valid && trig) begin
            state_d      = ST_POST;
            trig_addr_d  = wr_ptr;
            start_addr_d = wr_ptr - pre_len_q;
            // (2^AW - 1) - pre_len: remaining slots after pre window + trigger.
            post_cnt_d   = ~pre_len_q;
          end
        end
        ST_POST: begin
          if (post_cnt_q == '0) begin
            state_d = ST_DONE;
          end else if (sample_valid) begin
            post_cnt_d = post_cnt_q - 1'b1;
            if (post_cnt_q == AW'(1)) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (rd_release) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Controller state registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      pre_len_q    <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      pre_len_q    <= pre_len_d;
      pre_cnt_q    <= pre_cnt_d;
      post_cnt_q   <= post_cnt_d;
      trig_addr_q  <= trig_addr_d;
      start_addr_q <= start_addr_d;
    end
  end

  // Memory address mux: reader addresses are rebased to the oldest sample
  // while the reader owns the memory, otherwise the write pointer drives it.
  always_comb begin
    if (state_q == ST_DONE) mem_addr = start_addr_q + rd_addr_in;
    else                    mem_addr = wr_ptr;
  end

  assign rd_grant   = (state_q == ST_DONE);
  assign busy       = state_is_busy(state_q);
  assign state      = state_q;
  assign trig_addr  = trig_addr_q;
  assign start_addr = start_addr_q;

endmodule

// File: tb/tb_capture_mem_ctrl.sv
// Directed bench for capture_mem_ctrl at AW=4: full capture with trigger in
// mid-buffer, zero-length pre window, readout rebasing, abort and async reset.
module tb_capture_mem_ctrl;

  localparam int AW = 4;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  capture_mem_ctrl_if #(.AW(AW)) cif ();

  capture_mem_ctrl #(.AW(AW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .arm          (cif.arm),
    .abort        (cif.abort),
    .pre_count    (cif.pre_count),
    .sample_valid (cif.sample_valid),
    .trig         (cif.trig),
    .rd_addr_in   (cif.rd_addr_in),
    .rd_release   (cif.rd_release),
    .mem_addr     (cif.mem_addr),
    .wr_en        (cif.wr_en),
    .start_addr   (cif.start_addr),
    .trig_addr    (cif.trig_addr),
    .rd_grant     (cif.rd_grant),
    .busy         (cif.busy),
    .state        (cif.state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] ea;
    total = 0;
    bad   = 0;

    cif.arm = 1'b0; cif.abort = 1'b0; cif.pre_count = '0; cif.sample_valid = 1'b0;
    cif.trig = 1'b0; cif.rd_addr_in = '0; cif.rd_release = 1'b0;

    // ---------------- reset state ----------------
    reset_n = 1'b0;
    #12;
    check("rst_state",  cif.state,      3'd0);
    check("rst_wr_en",  cif.wr_en,      1'b0);
    check("rst_busy",   cif.busy,       1'b0);
    check("rst_grant",  cif.rd_grant,   1'b0);
    check("rst_addr",   cif.mem_addr,   4'd0);
    check("rst_trig",   cif.trig_addr,  4'd0);
    check("rst_start",  cif.start_addr, 4'd0);
    tick();
    reset_n = 1'b1;
    cif.sample_valid = 1'b1;
    settle();
    check("idle_no_wr", cif.wr_en, 1'b0);
    tick();
    check("idle_stay", cif.state, 3'd0);

    // ---------------- pre=4, trig at addr 9 ----------------
    cif.pre_count = 4'd4; cif.arm = 1'b1;
    settle();
    check("arm_no_wr", cif.wr_en, 1'b0);
    tick();
    cif.arm = 1'b0; cif.pre_count = 4'd9;  // late change must be ignored
    for (int i = 0; i < 4; i++) begin
      cif.trig = (i == 1);                 // trigger during PRE is ignored
      settle();
      ea = 4'(i);
      check("pre_state", cif.state,    3'd1);
      check("pre_addr",  cif.mem_addr, ea);
      check("pre_wr",    cif.wr_en,    1'b1);
      check("pre_busy",  cif.busy,     1'b1);
      tick();
    end
    cif.trig = 1'b0;
    for (int a = 4; a <= 9; a++) begin
      cif.trig = (a == 9);
      settle();
      ea = 4'(a);
      check("wait_state", cif.state,    3'd2);
      check("wait_addr",  cif.mem_addr, ea);
      tick();
    end
    cif.trig = 1'b0;
    settle();
    check("post_entry", cif.state,      3'd3);
    check("trig_addr",  cif.trig_addr,  4'd9);
    check("start_addr", cif.start_addr, 4'd5);
    for (int k = 0; k < 11; k++) begin
      ea = 4'(10 + k);
      if (k == 5) begin
        cif.sample_valid = 1'b0;           // gap: no write, no progress
        settle();
        check("post_gap_wr",    cif.wr_en,    1'b0);
        check("post_gap_addr",  cif.mem_addr, ea);
        tick();
        check("post_gap_state", cif.state,    3'd3);
        cif.sample_valid = 1'b1;
      end
      settle();
      check("post_state", cif.state,    3'd3);
      check("post_addr",  cif.mem_addr, ea);
      check("post_wr",    cif.wr_en,    1'b1);
      tick();
    end
    settle();
    check("done_state", cif.state,    3'd4);
    check("done_grant", cif.rd_grant, 1'b1);
    check("done_busy",  cif.busy,     1'b0);
    check("done_no_wr", cif.wr_en,    1'b0);

    // ---------------- readout ----------------
    cif.rd_addr_in = 4'd13;
    settle();
    check("rd_wrap_addr", cif.mem_addr, 4'd2);
    cif.arm = 1'b1; cif.trig = 1'b1;
    tick();
    cif.arm = 1'b0; cif.trig = 1'b0;
    check("done_arm_ign", cif.state,      3'd4);
    check("done_start",   cif.start_addr, 4'd5);
    cif.rd_addr_in = 4'd3;
    settle();
    check("rd_addr", cif.mem_addr, 4'd8);
    cif.rd_release = 1'b1;
    settle();
    check("rel_hold", cif.state, 3'd4);
    tick();
    cif.rd_release = 1'b0;
    settle();
    check("rel_idle",  cif.state,     3'd0);
    check("rel_grant", cif.rd_grant,  1'b0);
    check("rel_ptr",   cif.mem_addr,  4'd5);
    check("rel_trig",  cif.trig_addr, 4'd9);

    // ---------------- pre=0, trig on first WAIT sample ----------------
    cif.pre_count = 4'd0; cif.arm = 1'b1;
    tick();
    cif.arm = 1'b0;
    settle();
    check("p0_pre_state", cif.state,    3'd1);
    check("p0_pre_no_wr", cif.wr_en,    1'b0);
    check("p0_pre_addr",  cif.mem_addr, 4'd0);
    tick();
    cif.trig = 1'b1;
    settle();
    check("p0_wait_state", cif.state,    3'd2);
    check("p0_wait_addr",  cif.mem_addr, 4'd0);
    check("p0_wait_wr",    cif.wr_en,    1'b1);
    tick();
    cif.trig = 1'b0;
    settle();
    check("p0_post",  cif.state,      3'd3);
    check("p0_trig",  cif.trig_addr,  4'd0);
    check("p0_start", cif.start_addr, 4'd0);
    for (int k = 1; k <= 15; k++) begin
      settle();
      ea = 4'(k);
      check("p0_post_state", cif.state,    3'd3);
      check("p0_post_addr",  cif.mem_addr, ea);
      tick();
    end
    settle();
    check("p0_done", cif.state, 3'd4);
    cif.rd_release = 1'b1;
    tick();
    cif.rd_release = 1'b0;
    settle();
    check("p0_idle", cif.state,    3'd0);
    check("p0_ptr",  cif.mem_addr, 4'd0);

    // ---------------- abort during POST, arm while busy ----------------
    cif.pre_count = 4'd2; cif.arm = 1'b1;
    tick();
    cif.arm = 1'b0;
    tick();                                // write addr 0
    cif.arm = 1'b1; cif.pre_count = 4'd7;  // arm while busy: ignored
    settle();
    check("busy_arm_state", cif.state,    3'd1);
    check("busy_arm_addr",  cif.mem_addr, 4'd1);
    tick();                                // write addr 1 -> WAIT
    cif.arm = 1'b0;
    cif.trig = 1'b1;
    settle();
    check("ab_wait", cif.state, 3'd2);
    tick();                                // trigger write at addr 2
    cif.trig = 1'b0;
    settle();
    check("ab_trig",  cif.trig_addr,  4'd2);
    check("ab_start", cif.start_addr, 4'd0);
    tick();                                // post write addr 3
    cif.abort = 1'b1;
    settle();
    check("ab_cycle_wr",    cif.wr_en, 1'b0);
    check("ab_cycle_state", cif.state, 3'd3);
    tick();
    cif.abort = 1'b0;
    settle();
    check("ab_idle",  cif.state,      3'd0);
    check("ab_busy",  cif.busy,       1'b0);
    check("ab_keep_t", cif.trig_addr,  4'd2);
    check("ab_keep_s", cif.start_addr, 4'd0);
    check("ab_ptr",   cif.mem_addr,   4'd4);

    // abort beats arm in IDLE
    cif.arm = 1'b1; cif.abort = 1'b1;
    tick();
    cif.arm = 1'b0; cif.abort = 1'b0;
    settle();
    check("ab_over_arm", cif.state, 3'd0);

    // ---------------- async reset mid-WAIT ----------------
    cif.pre_count = 4'd3; cif.arm = 1'b1;
    tick();
    cif.arm = 1'b0;
    tick(); tick(); tick();                // writes 0,1,2 -> WAIT
    tick();                                // WAIT write 3
    settle();
    check("rs_wait", cif.state, 3'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check("rs_state", cif.state,      3'd0);
    check("rs_wr",    cif.wr_en,      1'b0);
    check("rs_busy",  cif.busy,       1'b0);
    check("rs_addr",  cif.mem_addr,   4'd0);
    check("rs_trig",  cif.trig_addr,  4'd0);
    check("rs_start", cif.start_addr, 4'd0);
    #1;
    reset_n = 1'b1;
    settle();
    check("rs_resume_wr", cif.wr_en, 1'b0);
    tick();
    check("rs_resume_state", cif.state, 3'd0);
    check("rs_resume_wr2",   cif.wr_en, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/capture_mem_ctrl.md
CAPTURE_MEM_CTRL -- requirements
Module: capture_mem_ctrl

Interface
REQ-001 SHALL have parameter: AW, default 12, sample-memory address width (depth 2^AW words).
REQ-002 SHALL have ports (clock and reset first):
  clk  in  1  sole clock, all state on posedge
  reset_n  in  1  asynchronous active-low reset
  arm  in  1  single-cycle request to start a capture
  abort  in  1  single-cycle request to cancel any capture or readout
  pre_count  in  AW  number of pre-trigger samples, latched at arm
  sample_valid  in  1  ADC sample present this cycle
  trig  in  1  trigger event, qualified by sample_valid
  rd_addr_in  in  AW  word address from SPI memory reader
  rd_release  in  1  single-cycle end of host readout
  mem_addr  out  AW  address to sample memory
  wr_en  out  1  sample memory write enable
  start_addr  out  AW  address of oldest captured sample
  trig_addr  out  AW  address holding trigger sample
  rd_grant  out  1  memory owned by SPI reader
  busy  out  1  capture in progress (PRE/WAIT/POST)
  state  out  3  FSM state code

Function
REQ-003 FSM states, codes SHALL be IDLE=0, PRE=1, WAIT=2, POST=3, DONE=4; state output = current code.
REQ-004 IDLE: arm -> PRE; wr pointer cleared to 0, pre counter cleared, pre_count latched; pre_count changes after arm SHALL be ignored.
REQ-005 wr_en SHALL equal sample_valid while state in {PRE, WAIT, POST} and abort low, else 0; write occurs in the cycle sample_valid is high (zero latency).
REQ-006 Each write SHALL increment the wr pointer modulo 2^AW (15 -> 0 for AW=4).
REQ-007 PRE: count writes; when count reaches latched pre_count -> WAIT; pre_count=0 SHALL go PRE -> WAIT in one cycle without writing; trig in PRE SHALL be ignored.
REQ-008 WAIT: circular writing continues; trig & sample_valid -> POST, trig_addr <= address written that cycle, post counter <= 2^AW-1-pre_count; trig without sample_valid SHALL be ignored.
REQ-009 POST: each write decrements post counter; write made with counter 1, or entry with counter 0, -> DONE; total samples = pre_count + 1 + post = 2^AW.
REQ-010 start_addr SHALL be (trig_addr - pre_count) mod 2^AW, registered on WAIT->POST transition.
REQ-011 DONE: rd_grant=1, wr_en=0, mem_addr = (start_addr + rd_addr_in) mod 2^AW combinationally; otherwise mem_addr = wr pointer.
REQ-012 DONE: rd_release -> IDLE, rd_grant drops next cycle; arm and trig in DONE SHALL be ignored.
REQ-013 abort SHALL have priority over arm, trig, rd_release: any state -> IDLE next cycle, wr_en 0 in abort cycle, trig_addr/start_addr retained.
REQ-014 busy SHALL be 1 exactly in PRE, WAIT, POST.
REQ-015 arm while busy SHALL be ignored (no restart).

Reset
REQ-016 reset_n low SHALL asynchronously force state=IDLE, all counters, wr pointer, trig_addr, start_addr, latched pre_count to 0; outputs wr_en=0, rd_grant=0, busy=0, mem_addr=0.
REQ-017 Reset deassertion mid-operation SHALL resume in IDLE; no write in the first cycle after deassertion unless arm was sampled.

Structure
REQ-018 State codes and default AW SHALL live in shared package dso_pkg.
REQ-019 One sub-module SHALL be used: capture_addr_gen (wrapping AW-bit write pointer with clear and enable, async reset).

Verification (AW=4)
REQ-020 pre_count=4, sample_valid constant, trig on addr 9 -> PRE writes 0..3, trig_addr=9, start_addr=5, POST writes 10..15,0..4, DONE after 11 post writes.
REQ-021 pre_count=0, trig on first WAIT sample (addr 0) -> no PRE write, 15 post writes, start_addr=0, trig_addr=0.
REQ-022 trig pulsed during PRE -> ignored, state stays PRE until 4th write.
REQ-023 DONE, start_addr=5, rd_addr_in=13 -> mem_addr=2; arm ignored; rd_release -> IDLE next cycle, rd_grant=0.
REQ-024 abort during POST -> state IDLE next cycle, wr_en=0 in abort cycle, busy=0.
REQ-025 reset_n low mid-WAIT (between clock edges) -> state=0, wr_en=0, busy=0 immediately, before next edge.
